// File: rtl/fifo_queue_counted_if.sv
// Handshake and status bundle for fifo_queue_counted.
//
// Signals:
//   request_in          producer payload
//   request_valid_in    producer has a payload
//   issue_ack_out       queue accepts the payload this cycle
//   request_out         head entry (first-word-fall-through)
//   request_valid_out   head entry valid
//   issue_ack_in        consumer takes the head this cycle
//   count_out           current occupancy
//   is_empty_out, is_full_out, almost_full_out, almost_empty_out  status flags
//
// Modports: slave = the queue, master = the producer/consumer side.
interface fifo_queue_counted_if #(
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int unsigned COUNT_WIDTH_IN_BITS        = 5
);
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in;
  logic                                  request_valid_in;
  logic                                  issue_ack_out;
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out;
  logic                                  request_valid_out;
  logic                                  issue_ack_in;
  logic [COUNT_WIDTH_IN_BITS-1:0]        count_out;
  logic                                  is_empty_out;
  logic                                  is_full_out;
  logic                                  almost_full_out;
  logic                                  almost_empty_out;

  modport slave (
    input  request_in,
    input  request_valid_in,
    input  issue_ack_in,
    output issue_ack_out,
    output request_out,
    output request_valid_out,
    output count_out,
    output is_empty_out,
    output is_full_out,
    output almost_full_out,
    output almost_empty_out
  );

  modport master (
    output request_in,
    output request_valid_in,
    output issue_ack_in,
    input  issue_ack_out,
    input  request_out,
    input  request_valid_out,
    input  count_out,
    input  is_empty_out,
    input  is_full_out,
    input  almost_full_out,
    input  almost_empty_out
  );
endinterface

// File: rtl/fifo_queue_counted.sv
// Counted first-word-fall-through FIFO for request pipelines.
//
// Any depth >= 2 (pointers wrap by explicit compare, so non-power-of-two depths work).
// Keeps an occupancy counter; all status flags are decoded from that register only.
// Enqueue and dequeue may both complete in the same cycle.
//
// Ports:
//   clk_in    clock
//   reset_in  asynchronous, active-high reset
//   flush_in  synchronous clear; drops any enq/deq in the same cycle
//   q_if      fifo_queue_counted_if.slave handshake and status bundle
//
// Build option:
//   FIFO_QUEUE_FULL_BYPASS_EN  when defined, a full queue that is being dequeued also
//                              accepts a new payload into the freed slot in the same cycle.
//                              This adds a combinational issue_ack_in -> issue_ack_out path.
module fifo_queue_counted #(
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int unsigned QUEUE_SIZE                 = 16,
  parameter int unsigned QUEUE_PTR_WIDTH_IN_BITS    = $clog2(QUEUE_SIZE),
  parameter int unsigned COUNT_WIDTH_IN_BITS        = $clog2(QUEUE_SIZE + 1),
  parameter int unsigned ALMOST_FULL_THRESHOLD      = QUEUE_SIZE - 2,
  parameter int unsigned ALMOST_EMPTY_THRESHOLD     = 2
) (
  input logic                clk_in,
  input logic                reset_in,
  input logic                flush_in,
  fifo_queue_counted_if.slave q_if
);

  typedef logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] entry_t;
  typedef logic [QUEUE_PTR_WIDTH_IN_BITS-1:0]    ptr_t;
  typedef logic [COUNT_WIDTH_IN_BITS-1:0]        count_t;

  localparam ptr_t   PtrLast      = QUEUE_PTR_WIDTH_IN_BITS'(QUEUE_SIZE - 1);
  localparam count_t CountFull    = COUNT_WIDTH_IN_BITS'(QUEUE_SIZE);
  localparam count_t CountAlmFull = COUNT_WIDTH_IN_BITS'(ALMOST_FULL_THRESHOLD);
  localparam count_t CountAlmEmpt = COUNT_WIDTH_IN_BITS'(ALMOST_EMPTY_THRESHOLD);

  entry_t storage_q [QUEUE_SIZE];
  entry_t storage_d [QUEUE_SIZE];
  ptr_t   write_ptr_q, write_ptr_d;
  ptr_t   read_ptr_q,  read_ptr_d;
  count_t count_q,     count_d;

  logic is_empty;
  logic is_full;
  logic issue_ack;
  logic head_valid;
  logic enq;
  logic deq;

  // Explicit wrap so depths that are not a power of two never index past the array.
  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  // Status decode from the count register only.
  always_comb begin
    is_empty   = (count_q == '0);
    is_full    = (count_q == CountFull);
    head_valid = ~is_empty;
  end

`ifdef FIFO_QUEUE_FULL_BYPASS_EN
  // When full, the slot being dequeued this cycle is the one write_ptr points at,
  // so the incoming payload can land there at the same edge.
  assign issue_ack = ~is_full | (head_valid & q_if.issue_ack_in);
`else
  assign issue_ack = ~is_full;
`endif

  assign enq = q_if.request_valid_in & issue_ack;
  assign deq = head_valid & q_if.issue_ack_in;

  // Next-state: flush wins over any enq/deq; storage is left as-is because the
  // reset pointers and zero count make old contents unreachable.
  always_comb begin
    storage_d   = storage_q;
    write_ptr_d = write_ptr_q;
    read_ptr_d  = read_ptr_q;
    count_d     = count_q;

    if (flush_in) begin
      write_ptr_d = '0;
      read_ptr_d  = '0;
      count_d     = '0;
    end else begin
      if (enq) begin
        storage_d[write_ptr_q] = q_if.request_in;
        write_ptr_d            = next_ptr(write_ptr_q);
      end
      if (deq) begin
        read_ptr_d = next_ptr(read_ptr_q);
      end
      unique case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      storage_q   <= '{default: '0};
      write_ptr_q <= '0;
      read_ptr_q  <= '0;
      count_q     <= '0;
    end else begin
      storage_q   <= storage_d;
      write_ptr_q <= write_ptr_d;
      read_ptr_q  <= read_ptr_d;
      count_q     <= count_d;
    end
  end

  // Outputs
  assign q_if.issue_ack_out     = issue_ack;
  assign q_if.request_valid_out = head_valid;
  assign q_if.request_out       = head_valid ? storage_q[read_ptr_q] : '0;
  assign q_if.count_out         = count_q;
  assign q_if.is_empty_out      = is_empty;
  assign q_if.is_full_out       = is_full;
  assign q_if.almost_full_out   = (count_q >= CountAlmFull);
  assign q_if.almost_empty_out  = (count_q <= CountAlmEmpt);

endmodule

// File: tb/tb_fifo_queue_counted.sv
module tb_fifo_queue_counted;

`ifdef FIFO_QUEUE_FULL_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic clk_in   = 1'b0;
  logic reset_in = 1'b1;
  logic flush5   = 1'b0;
  logic flush16  = 1'b0;

  always #5 clk_in = ~clk_in;

  fifo_queue_counted_if #(.SINGLE_ENTRY_WIDTH_IN_BITS(64), .COUNT_WIDTH_IN_BITS(3)) a_if ();
  fifo_queue_counted_if #(.SINGLE_ENTRY_WIDTH_IN_BITS(64), .COUNT_WIDTH_IN_BITS(5)) b_if ();

  fifo_queue_counted #(.SINGLE_ENTRY_WIDTH_IN_BITS(64), .QUEUE_SIZE(5)) dut5 (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .flush_in(flush5),
    .q_if    (a_if.slave)
  );

  fifo_queue_counted #(.SINGLE_ENTRY_WIDTH_IN_BITS(64), .QUEUE_SIZE(16)) dut16 (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .flush_in(flush16),
    .q_if    (b_if.slave)
  );

  typedef struct packed {
    logic        fl;
    logic        v;
    logic [63:0] d;
    logic        a;
    logic        ack;
    logic        vo;
    logic [63:0] dout;
    logic [4:0]  cnt;
    logic [3:0]  flags;  // {empty, full, almost_full, almost_empty}
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs [39];
  logic [63:0] model [$];

  function automatic vec_t mk(input logic fl, input logic v, input logic [63:0] d,
                              input logic a, input logic ack, input logic vo,
                              input logic [63:0] dout, input logic [4:0] cnt,
                              input logic [3:0] flags);
    vec_t r;
    r.fl = fl; r.v = v; r.d = d; r.a = a;
    r.ack = ack; r.vo = vo; r.dout = dout; r.cnt = cnt; r.flags = flags;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step16(input logic fl, input logic v, input logic [63:0] d, input logic a);
    @(negedge clk_in);
    flush16               = fl;
    b_if.request_valid_in = v;
    b_if.request_in       = d;
    b_if.issue_ack_in     = a;
    #1;
  endtask

  initial begin
    // QUEUE_SIZE=5 table: inputs, then outputs seen before the following edge.
    //              fl v  d      a   ack  vo dout   cnt flags
    vecs[0]  = mk(0, 0, 64'h00, 0, 1,   0, 64'h00, 0, 4'b1001);
    vecs[1]  = mk(0, 1, 64'hA1, 0, 1,   0, 64'h00, 0, 4'b1001);
    vecs[2]  = mk(0, 0, 64'h00, 0, 1,   1, 64'hA1, 1, 4'b0001);
    vecs[3]  = mk(0, 0, 64'h00, 1, 1,   1, 64'hA1, 1, 4'b0001);
    vecs[4]  = mk(0, 1, 64'h10, 0, 1,   0, 64'h00, 0, 4'b1001);
    vecs[5]  = mk(0, 1, 64'h11, 0, 1,   1, 64'h10, 1, 4'b0001);
    vecs[6]  = mk(0, 1, 64'h12, 0, 1,   1, 64'h10, 2, 4'b0001);
    vecs[7]  = mk(0, 1, 64'h13, 0, 1,   1, 64'h10, 3, 4'b0010);
    vecs[8]  = mk(0, 1, 64'h14, 0, 1,   1, 64'h10, 4, 4'b0010);
    vecs[9]  = mk(0, 1, 64'h15, 0, 0,   1, 64'h10, 5, 4'b0110);
    vecs[10] = mk(0, 0, 64'h00, 0, 0,   1, 64'h10, 5, 4'b0110);
    vecs[11] = mk(0, 0, 64'h00, 1, Byp, 1, 64'h10, 5, 4'b0110);
    vecs[12] = mk(0, 0, 64'h00, 1, 1,   1, 64'h11, 4, 4'b0010);
    vecs[13] = mk(0, 0, 64'h00, 1, 1,   1, 64'h12, 3, 4'b0010);
    vecs[14] = mk(0, 0, 64'h00, 1, 1,   1, 64'h13, 2, 4'b0001);
    vecs[15] = mk(0, 0, 64'h00, 1, 1,   1, 64'h14, 1, 4'b0001);
    vecs[16] = mk(0, 0, 64'h00, 1, 1,   0, 64'h00, 0, 4'b1001);
    vecs[17] = mk(0, 1, 64'h20, 1, 1,   0, 64'h00, 0, 4'b1001);
    vecs[18] = mk(0, 0, 64'h00, 1, 1,   1, 64'h20, 1, 4'b0001);
    vecs[19] = mk(0, 1, 64'h10, 0, 1,   0, 64'h00, 0, 4'b1001);
    vecs[20] = mk(0, 1, 64'h11, 0, 1,   1, 64'h10, 1, 4'b0001);
    vecs[21] = mk(0, 1, 64'h12, 0, 1,   1, 64'h10, 2, 4'b0001);
    vecs[22] = mk(0, 1, 64'h13, 0, 1,   1, 64'h10, 3, 4'b0010);
    vecs[23] = mk(0, 1, 64'h14, 0, 1,   1, 64'h10, 4, 4'b0010);
    vecs[24] = mk(0, 0, 64'h00, 1, Byp, 1, 64'h10, 5, 4'b0110);
    vecs[25] = mk(0, 0, 64'h00, 1, 1,   1, 64'h11, 4, 4'b0010);
    vecs[26] = mk(0, 0, 64'h00, 1, 1,   1, 64'h12, 3, 4'b0010);
    vecs[27] = mk(0, 0, 64'h00, 1, 1,   1, 64'h13, 2, 4'b0001);
    vecs[28] = mk(0, 0, 64'h00, 1, 1,   1, 64'h14, 1, 4'b0001);
    vecs[29] = mk(0, 0, 64'h00, 0, 1,   0, 64'h00, 0, 4'b1001);
    vecs[30] = mk(0, 1, 64'h31, 0, 1,   0, 64'h00, 0, 4'b1001);
    vecs[31] = mk(0, 1, 64'h32, 0, 1,   1, 64'h31, 1, 4'b0001);
    vecs[32] = mk(0, 1, 64'h33, 0, 1,   1, 64'h31, 2, 4'b0001);
    vecs[33] = mk(1, 1, 64'h99, 1, 1,   1, 64'h31, 3, 4'b0010);
    vecs[34] = mk(0, 0, 64'h00, 0, 1,   0, 64'h00, 0, 4'b1001);
    vecs[35] = mk(0, 1, 64'h40, 0, 1,   0, 64'h00, 0, 4'b1001);
    vecs[36] = mk(0, 0, 64'h00, 0, 1,   1, 64'h40, 1, 4'b0001);
    vecs[37] = mk(0, 0, 64'h00, 1, 1,   1, 64'h40, 1, 4'b0001);
    vecs[38] = mk(0, 0, 64'h00, 0, 1,   0, 64'h00, 0, 4'b1001);

    a_if.request_valid_in = 1'b0; a_if.request_in = '0; a_if.issue_ack_in = 1'b0;
    b_if.request_valid_in = 1'b0; b_if.request_in = '0; b_if.issue_ack_in = 1'b0;
    #12 reset_in = 1'b0;

    for (int i = 0; i < 39; i++) begin
      @(negedge clk_in);
      flush5                = vecs[i].fl;
      a_if.request_valid_in = vecs[i].v;
      a_if.request_in       = vecs[i].d;
      a_if.issue_ack_in     = vecs[i].a;
      #1;
      n_vec++;
      if ({a_if.issue_ack_out, a_if.request_valid_out, a_if.request_out,
           2'b00, a_if.count_out, a_if.is_empty_out, a_if.is_full_out,
           a_if.almost_full_out, a_if.almost_empty_out} !==
          {vecs[i].ack, vecs[i].vo, vecs[i].dout, vecs[i].cnt, vecs[i].flags}) begin
        n_err++;
        $display("FAIL vec[%0d]: got ack=%b vo=%b dout=%0h cnt=%0d flags=%b, expected ack=%b vo=%b dout=%0h cnt=%0d flags=%b",
                 i, a_if.issue_ack_out, a_if.request_valid_out, a_if.request_out, a_if.count_out,
                 {a_if.is_empty_out, a_if.is_full_out, a_if.almost_full_out, a_if.almost_empty_out},
                 vecs[i].ack, vecs[i].vo, vecs[i].dout, vecs[i].cnt, vecs[i].flags);
      end
    end
    @(negedge clk_in);
    flush5 = 1'b0; a_if.request_valid_in = 1'b0; a_if.issue_ack_in = 1'b0;

    // QUEUE_SIZE=16: fill 0..16 and watch the threshold flags.
    for (int k = 0; k <= 16; k++) begin
      step16(0, (k < 16), 64'(100 + k), 0);
      if (k < 16) model.push_back(64'(100 + k));
      chk("fill_status", {b_if.count_out, b_if.is_empty_out, b_if.is_full_out,
                          b_if.almost_full_out, b_if.almost_empty_out},
          {5'(k), (k == 0), (k == 16), (k >= 14), (k <= 2)});
    end

    // Full with simultaneous enqueue and dequeue.
    step16(0, 1, 64'h55, 1);
    chk("full_rw_ack", {b_if.issue_ack_out, b_if.request_out}, {Byp, 64'd100});
    void'(model.pop_front());
    if (Byp) model.push_back(64'h55);
    step16(0, 0, 0, 0);
    chk("full_rw_count", b_if.count_out, Byp ? 5'd16 : 5'd15);

    // Drain and compare order; bounded by the model size.
    for (int g = 0; g < 20 && model.size() > 0; g++) begin
      step16(0, 0, 0, 1);
      chk("drain_head", {b_if.request_valid_out, b_if.request_out}, {1'b1, model[0]});
      void'(model.pop_front());
    end
    step16(0, 0, 0, 0);
    chk("drain_empty", {b_if.count_out, b_if.request_valid_out, b_if.is_empty_out},
        {5'd0, 1'b0, 1'b1});

    // Steady enq+deq at count 3.
    for (int i = 0; i < 3; i++) begin
      step16(0, 1, 64'(200 + i), 0);
      model.push_back(64'(200 + i));
    end
    for (int i = 0; i < 20; i++) begin
      step16(0, 1, 64'(300 + i), 1);
      chk("steady", {b_if.count_out, b_if.request_valid_out, b_if.request_out,
                     b_if.almost_full_out, b_if.almost_empty_out},
          {5'd3, 1'b1, model[0], 1'b0, 1'b0});
      void'(model.pop_front());
      model.push_back(64'(300 + i));
    end

    // Flush at count 7 with enq and deq both requested.
    for (int i = 0; i < 4; i++) step16(0, 1, 64'(400 + i), 0);
    step16(1, 1, 64'h99, 1);
    chk("flush_pre_count", b_if.count_out, 5'd7);
    step16(0, 0, 0, 0);
    chk("flush_post", {b_if.count_out, b_if.request_valid_out, b_if.request_out},
        {5'd0, 1'b0, 64'd0});
    model.delete();
    step16(0, 1, 64'h77, 0);
    step16(0, 0, 0, 0);
    chk("post_flush_write", {b_if.count_out, b_if.request_out}, {5'd1, 64'h77});

    // Asynchronous reset between edges.
    step16(0, 1, 64'h78, 0);
    step16(0, 0, 0, 0);
    chk("pre_reset_count", b_if.count_out, 5'd2);
    #2 reset_in = 1'b1;
    #1;
    chk("async_reset", {b_if.count_out, b_if.request_valid_out, b_if.is_empty_out,
                        b_if.issue_ack_out, b_if.request_out},
        {5'd0, 1'b0, 1'b1, 1'b1, 64'd0});
    #2 reset_in = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
